// File: rtl/btle_pkg.sv
// Shared types and constants for the BTLE receive-side packet buffer.
package btle_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 9;
  localparam int unsigned CNT_WIDTH_DEF  = 16;
  localparam int unsigned LAST_BIT       = 9;
  localparam int unsigned CRC_BIT        = 8;
  localparam int unsigned WORD_W         = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CLOSE = 2'd2
  } rx_state_t;

  // Stored RAM word: last at LAST_BIT, crc_ok at CRC_BIT, octet below.
  typedef struct packed {
    logic       last;
    logic       crc_ok;
    logic [7:0] octet;
  } rx_word_t;

endpackage

// File: rtl/btle_dp_ram.sv
// Simple dual-port RAM: clocked write port, asynchronous read port.
module btle_dp_ram #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/btle_rx_pdu_buffer.sv
// Captures btle_rx_core octets into a circular buffer, commits or rolls back
// each packet on decode_end, and streams committed packets out valid/ready.
module btle_rx_pdu_buffer
  import btle_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drop_bad_crc,
  input  logic                  hit_flag,
  input  logic [7:0]            octet,
  input  logic                  octet_valid,
  input  logic                  decode_end,
  input  logic                  crc_ok,
  output logic [7:0]            out_octet,
  output logic                  out_last,
  output logic                  out_crc_ok,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  pkt_avail,
  output logic [ADDR_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0]  crc_err_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  rx_state_t             state;
  logic [ADDR_WIDTH-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [7:0]            pend_octet;
  logic                  pend_full, ovf_flag, crc_latched;

  logic [ADDR_WIDTH-1:0] wr_ptr_inc_c, pkt_count_nxt_c;
  logic                  full_c, recv_abort_c, recv_oct_c, recv_wr_c, recv_ovf_c;
  logic                  close_commit_c, close_drop_c, ram_we_c, load_c, last_acc_c;
  rx_word_t              ram_wdata_c, ram_rdata_c;

  assign wr_ptr_inc_c = wr_ptr + ADDR_WIDTH'(1);
  assign full_c       = (wr_ptr_inc_c == rd_ptr);

  // A new hit_flag without decode_end abandons the packet in flight.
  assign recv_abort_c = (state == RECV) && hit_flag && !decode_end;
  assign recv_oct_c   = (state == RECV) && octet_valid && !ovf_flag && !recv_abort_c;
  assign recv_wr_c    = recv_oct_c && pend_full && !full_c;
  assign recv_ovf_c   = recv_oct_c && pend_full && full_c;

  // ovf_flag can only be set with pending full, so every non-empty packet that
  // is not committed here counts as a drop.
  assign close_commit_c = (state == CLOSE) && pend_full && !ovf_flag &&
                          !(!crc_latched && drop_bad_crc) && !full_c;
  assign close_drop_c   = (state == CLOSE) && pend_full && !close_commit_c;

  assign ram_we_c   = recv_wr_c || close_commit_c;
  assign load_c     = (!out_valid || out_ready) && (rd_ptr != commit_ptr);
  assign last_acc_c = out_valid && out_ready && out_last;

  always_comb begin
    ram_wdata_c        = '0;
    ram_wdata_c.last   = close_commit_c;
    ram_wdata_c.crc_ok = close_commit_c && crc_latched;
    ram_wdata_c.octet  = pend_octet;
  end

  always_comb begin
    pkt_count_nxt_c = pkt_count;
    if (close_commit_c && !last_acc_c)      pkt_count_nxt_c = pkt_count + ADDR_WIDTH'(1);
    else if (!close_commit_c && last_acc_c) pkt_count_nxt_c = pkt_count - ADDR_WIDTH'(1);
  end

  btle_dp_ram #(
    .WIDTH      (WORD_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we_c),
    .waddr   (wr_ptr),
    .wdata   (ram_wdata_c),
    .raddr   (rd_ptr),
    .rdata_c (ram_rdata_c)
  );

  // Write-side FSM: speculative capture, then commit or roll back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      pend_octet  <= '0;
      pend_full   <= 1'b0;
      ovf_flag    <= 1'b0;
      crc_latched <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit_flag) begin
            state     <= RECV;
            pend_full <= 1'b0;
            ovf_flag  <= 1'b0;
          end
        end
        RECV: begin
          if (recv_abort_c) begin
            wr_ptr    <= commit_ptr;
            pend_full <= 1'b0;
            ovf_flag  <= 1'b0;
          end else begin
            if (recv_wr_c) wr_ptr <= wr_ptr_inc_c;
            if (recv_ovf_c) ovf_flag <= 1'b1;
            if (recv_oct_c && !recv_ovf_c) begin
              pend_octet <= octet;
              pend_full  <= 1'b1;
            end
            if (decode_end) begin
              crc_latched <= crc_ok;
              state       <= CLOSE;
            end
          end
        end
        CLOSE: begin
          if (close_commit_c) begin
            wr_ptr     <= wr_ptr_inc_c;
            commit_ptr <= wr_ptr_inc_c;
          end else begin
            wr_ptr <= commit_ptr;
          end
          pend_full <= 1'b0;
          ovf_flag  <= 1'b0;
          state     <= hit_flag ? RECV : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read side: one-word output register refilled whenever it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_crc_ok <= 1'b0;
      out_octet  <= '0;
    end else if (load_c) begin
      rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
      out_valid  <= 1'b1;
      out_last   <= ram_rdata_c.last;
      out_crc_ok <= ram_rdata_c.crc_ok;
      out_octet  <= ram_rdata_c.octet;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count   <= '0;
      pkt_avail   <= 1'b0;
      crc_err_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      pkt_count <= pkt_count_nxt_c;
      pkt_avail <= (pkt_count_nxt_c != '0);
      if ((state == CLOSE) && !crc_latched && (crc_err_cnt != CNT_MAX))
        crc_err_cnt <= crc_err_cnt + CNT_WIDTH'(1);
      if ((recv_abort_c || close_drop_c) && (drop_cnt != CNT_MAX))
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_btle_rx_pdu_buffer.sv
// Bench for btle_rx_pdu_buffer: packet-level queue model, per-cycle output compare.
module tb_btle_rx_pdu_buffer;

  localparam int unsigned AW  = 6;
  localparam int unsigned CW  = 4;
  localparam int CAP     = (1 << AW) - 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0, rst = 1'b1;
  logic          drop_bad_crc = 1'b0, hit_flag = 1'b0, octet_valid = 1'b0;
  logic          decode_end = 1'b0, crc_ok = 1'b0, out_ready = 1'b0;
  logic [7:0]    octet = 8'h00;
  logic [7:0]    out_octet;
  logic          out_last, out_crc_ok, out_valid, pkt_avail;
  logic [AW-1:0] pkt_count;
  logic [CW-1:0] crc_err_cnt, drop_cnt;

  always #5 clk = ~clk;

  btle_rx_pdu_buffer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .drop_bad_crc(drop_bad_crc), .hit_flag(hit_flag),
    .octet(octet), .octet_valid(octet_valid), .decode_end(decode_end), .crc_ok(crc_ok),
    .out_octet(out_octet), .out_last(out_last), .out_crc_ok(out_crc_ok),
    .out_valid(out_valid), .out_ready(out_ready), .pkt_avail(pkt_avail),
    .pkt_count(pkt_count), .crc_err_cnt(crc_err_cnt), .drop_cnt(drop_cnt)
  );

  int         tests = 0, fails = 0;
  logic [9:0] exp_q[$];
  logic [7:0] cur[$];
  int         m_commits = 0, m_lasts = 0, m_crc_err = 0, m_drop = 0, beats_seen = 0;
  bit         in_pkt = 1'b0;
  logic [9:0] last_beat_word = '0;
  logic [9:0] w;
  int         ready_mode = 0;
  logic       ready_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Packet-level model: decide the fate of the whole packet at close time.
  task automatic model_close(input bit crc);
    int n;
    n = cur.size();
    if (!crc) m_crc_err = sat(m_crc_err);
    if (n == 0) begin
    end else if ((exp_q.size() + n > CAP) || (!crc && drop_bad_crc)) begin
      m_drop = sat(m_drop);
    end else begin
      for (int i = 0; i < n; i++)
        exp_q.push_back({1'(i == n - 1), 1'((i == n - 1) && crc), cur[i]});
      m_commits++;
    end
  endtask

  task automatic start_pkt();
    hit_flag = 1'b1;
    tick(1);
    hit_flag = 1'b0;
    if (in_pkt) m_drop = sat(m_drop);
    cur.delete();
    in_pkt = 1'b1;
  endtask

  task automatic send_octets(input int n, input int base, input bit rnd,
                             input bit end_on_last, input bit crc);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = rnd ? 8'($urandom) : 8'(base + i);
      tick(15);
      octet       = b;
      octet_valid = 1'b1;
      decode_end  = end_on_last && (i == n - 1);
      crc_ok      = crc;
      tick(1);
      octet_valid = 1'b0;
      decode_end  = 1'b0;
      cur.push_back(b);
    end
  endtask

  task automatic close_pkt(input bit crc, input bit end_sent, input bit hit_next);
    if (!end_sent) begin
      tick(2);
      decode_end = 1'b1;
      crc_ok     = crc;
      tick(1);
      decode_end = 1'b0;
    end
    hit_flag = hit_next;
    tick(1);
    hit_flag = 1'b0;
    model_close(crc);
    cur.delete();
    in_pkt = hit_next;
  endtask

  task automatic send_pkt(input int n, input bit crc, input bit coinc, input bit hit_next,
                          input int base, input bit rnd);
    if (!in_pkt) start_pkt();
    send_octets(n, base, rnd, coinc && (n > 0), crc);
    close_pkt(crc, coinc && (n > 0), hit_next);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 3000) begin
      tick(1);
      k++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_valid_idle"}, 32'(out_valid), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = ready_hold;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Per-cycle comparison of status outputs and accepted beats against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("pkt_count", 32'(pkt_count), 32'(m_commits - m_lasts));
      check("pkt_avail", 32'(pkt_avail), 32'(m_commits != m_lasts));
      check("crc_err_cnt", 32'(crc_err_cnt), 32'(m_crc_err));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {22'd0, out_last, out_crc_ok, out_octet}, 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check("beat", {22'd0, out_last, out_crc_ok, out_octet}, {22'd0, w});
          beats_seen++;
          if (w[9]) begin
            m_lasts++;
            last_beat_word = {out_last, out_crc_ok, out_octet};
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, l0, n;
    bit crc, coinc, hn;
    tick(3);
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_octet", 32'(out_octet), 32'd0);

    // 1: good 11-octet packet, decode_end with the last octet
    ready_hold = 1'b1;
    b0 = beats_seen;
    send_pkt(11, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check("t1_pkt_count_1", 32'(pkt_count), 32'd1);
    drain("t1");
    check("t1_beats", 32'(beats_seen - b0), 32'd11);
    check("t1_last_word", 32'(last_beat_word), 32'h30A);
    check("t1_pkt_count_0", 32'(pkt_count), 32'd0);
    check("t1_drop", 32'(drop_cnt), 32'd0);

    // 2: bad CRC dropped, then bad CRC committed flagged
    drop_bad_crc = 1'b1;
    send_pkt(11, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    tick(3);
    check("t2_no_valid", 32'(out_valid), 32'd0);
    check("t2_crc_err", 32'(crc_err_cnt), 32'd1);
    check("t2_drop", 32'(drop_cnt), 32'd1);
    drop_bad_crc = 1'b0;
    b0 = beats_seen;
    send_pkt(11, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    drain("t2b");
    check("t2b_beats", 32'(beats_seen - b0), 32'd11);
    check("t2b_last_word", 32'(last_beat_word), 32'h20A);
    check("t2b_crc_err", 32'(crc_err_cnt), 32'd2);

    // 3: three packets queued, then drained with toggling ready
    ready_hold = 1'b0;
    tick(2);
    b0 = beats_seen;
    l0 = m_lasts;
    send_pkt(11, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
    send_pkt(11, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0);
    send_pkt(11, 1'b1, 1'b0, 1'b0, 8'h30, 1'b0);
    check("t3_pkt_count_3", 32'(pkt_count), 32'd3);
    ready_mode = 1;
    drain("t3");
    ready_mode = 0;
    check("t3_beats", 32'(beats_seen - b0), 32'd33);
    check("t3_lasts", 32'(m_lasts - l0), 32'd3);
    check("t3_pkt_count_0", 32'(pkt_count), 32'd0);

    // 4: overflow drop, recovery, and the exact-capacity boundary
    ready_hold = 1'b0;
    tick(2);
    send_pkt(70, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    tick(3);
    check("t4_ovf_drop", 32'(drop_cnt), 32'd2);
    check("t4_ovf_no_valid", 32'(out_valid), 32'd0);
    send_pkt(5, 1'b1, 1'b1, 1'b0, 8'h50, 1'b0);
    check("t4_small_commit", 32'(pkt_count), 32'd1);
    ready_hold = 1'b1;
    drain("t4_small");
    ready_hold = 1'b0;
    tick(2);
    send_pkt(CAP, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    check("t4_cap_commit", 32'(pkt_count), 32'd1);
    check("t4_cap_drop", 32'(drop_cnt), 32'd2);
    ready_hold = 1'b1;
    drain("t4_cap");
    ready_hold = 1'b0;
    tick(2);
    send_pkt(CAP + 1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    check("t4_cap1_drop", 32'(drop_cnt), 32'd3);
    check("t4_cap1_count", 32'(pkt_count), 32'd0);

    // 5: second hit_flag aborts the first packet
    ready_hold = 1'b1;
    b0 = beats_seen;
    start_pkt();
    send_octets(4, 8'h60, 1'b0, 1'b0, 1'b1);
    start_pkt();
    send_pkt(3, 1'b1, 1'b0, 1'b0, 8'h70, 1'b0);
    drain("t5");
    check("t5_beats", 32'(beats_seen - b0), 32'd3);
    check("t5_drop", 32'(drop_cnt), 32'd4);

    // empty packet, and hit_flag arriving in the close cycle
    start_pkt();
    close_pkt(1'b0, 1'b0, 1'b0);
    check("empty_crc_err", 32'(crc_err_cnt), 32'd3);
    check("empty_drop", 32'(drop_cnt), 32'd4);
    b0 = beats_seen;
    send_pkt(4, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0);
    send_pkt(2, 1'b1, 1'b1, 1'b0, 8'h90, 1'b0);
    drain("b2b");
    check("b2b_beats", 32'(beats_seen - b0), 32'd6);

    // randomized traffic with random back-pressure
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int k;
      n     = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      crc   = ($urandom_range(0, 3) != 0);
      coinc = 1'($urandom_range(0, 1));
      hn    = ($urandom_range(0, 3) == 0);
      if (!in_pkt) drop_bad_crc = 1'($urandom_range(0, 1));
      k = 0;
      while ((exp_q.size() + 20 > CAP) && k < 3000) begin
        tick(1);
        k++;
      end
      if ($urandom_range(0, 6) == 0) begin
        if (!in_pkt) start_pkt();
        send_octets(int'($urandom_range(0, 6)), 0, 1'b1, 1'b0, 1'b1);
        start_pkt();
      end
      send_pkt(n, crc, coinc, hn, 0, 1'b1);
    end
    if (in_pkt) close_pkt(1'b1, 1'b0, 1'b0);
    drain("rand");
    ready_mode = 0;

    // 6: reset mid-packet with an unread packet queued
    ready_hold = 1'b0;
    tick(2);
    send_pkt(3, 1'b1, 1'b1, 1'b0, 8'hA0, 1'b0);
    start_pkt();
    send_octets(5, 8'hB0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    cur.delete();
    in_pkt = 1'b0;
    m_commits = 0; m_lasts = 0; m_crc_err = 0; m_drop = 0;
    rst = 1'b0;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_out_last", 32'(out_last), 32'd0);
    check("t6_out_crc_ok", 32'(out_crc_ok), 32'd0);
    check("t6_out_octet", 32'(out_octet), 32'd0);
    check("t6_pkt_count", 32'(pkt_count), 32'd0);
    check("t6_crc_err", 32'(crc_err_cnt), 32'd0);
    check("t6_drop", 32'(drop_cnt), 32'd0);
    ready_hold = 1'b1;
    b0 = beats_seen;
    send_pkt(2, 1'b1, 1'b1, 1'b0, 8'hC0, 1'b0);
    drain("t6");
    check("t6_beats", 32'(beats_seen - b0), 32'd2);

    // counter saturation
    for (int i = 0; i < 16; i++) begin
      start_pkt();
      close_pkt(1'b0, 1'b0, 1'b0);
    end
    check("sat_crc_err", 32'(crc_err_cnt), 32'(CNT_MAX));
    start_pkt();
    for (int i = 0; i < 16; i++) start_pkt();
    close_pkt(1'b1, 1'b0, 1'b0);
    check("sat_drop", 32'(drop_cnt), 32'(CNT_MAX));
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btle_rx_pdu_buffer.md
Name: btle_rx_pdu_buffer

Overview:
Packet buffer directly downstream of btle_rx_core. It captures the octet stream the core emits between hit_flag and decode_end into a circular RAM. On decode_end it either commits the packet (good CRC, or bad CRC when bad packets are allowed) or rolls it back. Committed packets are presented to the host/MAC side as a valid/ready octet stream with last and crc_ok sideband.

Parameters:
ADDR_WIDTH, 9, log2 of buffer depth in words (512 words)
CNT_WIDTH, 16, width of the saturating statistics counters

Ports:
clk  input  1  system clock (16 MHz in the reference system)
rst  input  1  synchronous, active-high reset
drop_bad_crc  input  1  1: discard packets with crc_ok=0; 0: commit them flagged
hit_flag  input  1  from btle_rx_core; start of packet
octet  input  8  from btle_rx_core
octet_valid  input  1  from btle_rx_core
decode_end  input  1  from btle_rx_core; end of packet
crc_ok  input  1  from btle_rx_core; qualified by decode_end
out_octet  output  8  stored octet
out_last  output  1  final octet of the packet
out_crc_ok  output  1  packet CRC status; meaningful when out_last=1
out_valid  output  1  output beat available
out_ready  input  1  consumer accepts the beat
pkt_avail  output  1  pkt_count != 0
pkt_count  output  ADDR_WIDTH  committed packets not yet fully read
crc_err_cnt  output  CNT_WIDTH  packets ending with crc_ok=0
drop_cnt  output  CNT_WIDTH  packets discarded (CRC, overflow, abort)

Behaviour:
- Reset: all pointers = 0; FSM = IDLE; pending register empty; out_valid=0, out_last=0, out_crc_ok=0, out_octet=0, pkt_count=0, both counters = 0. Reset mid-packet or mid-read discards everything.
- RAM word = {last, crc_ok, octet} (10 bits). RAM is asynchronous-read and written on the clock edge.
- Pointers are ADDR_WIDTH bits wide and wrap modulo depth: wr_ptr (speculative), commit_ptr, rd_ptr. The buffer is full when wr_ptr+1 == rd_ptr.
- Pending register: holds the most recent octet until it is known whether that octet is the last one.
- FSM states:
  - IDLE: on hit_flag, go to RECV, clear pending and ovf_flag. octet_valid in IDLE is ignored.
  - RECV: on octet_valid, if pending is full, write {0,0,pending} at wr_ptr and increment wr_ptr. Then load pending with octet.
    - If the write would hit the full condition, set ovf_flag, suppress the write, and ignore further octets.
    - On decode_end, latch crc_ok and go to CLOSE. An octet_valid in the same cycle as decode_end is processed first, so it becomes the last octet.
    - On hit_flag without a preceding decode_end: roll back (wr_ptr <= commit_ptr), drop_cnt++, restart RECV.
  - CLOSE (exactly 1 cycle):
    - crc_ok=0: crc_err_cnt++.
    - Discard when ovf_flag is set, or pending is empty, or (crc_ok=0 and drop_bad_crc=1). Discard means wr_ptr <= commit_ptr, drop_cnt++ (except the empty case, which leaves drop_cnt unchanged).
    - Otherwise, if the final write is possible: write {1,crc_ok,pending} and set commit_ptr <= wr_ptr+1 and wr_ptr <= wr_ptr+1. pkt_count++.
    - If the buffer is full at this final write, treat it as an overflow discard.
    - Return to IDLE. A hit_flag arriving in CLOSE is honoured, going to RECV instead of IDLE.
- Output (first-word fall-through with a register stage):
  - When (!out_valid || out_ready) and rd_ptr != commit_ptr: load out_* from mem[rd_ptr], rd_ptr++, out_valid=1.
  - Else if out_ready: out_valid=0.
  - First beat appears 1 cycle after the commit_ptr update. Sustained throughput is 1 beat/clk.
- pkt_count: +1 on commit, -1 on an accepted beat with out_last. Both in the same cycle leaves it unchanged.
- Counters saturate at all-ones.
- The block never back-pressures btle_rx_core. Octets arrive at most once per 16 clk, so the write side always keeps up.

Decomposition:
- Shared package btle_pkg: FSM state encoding (IDLE/RECV/CLOSE), RAM word field offsets (LAST_BIT=9, CRC_BIT=8), default ADDR_WIDTH.
- One sub-module is natural: btle_dp_ram (simple dual-port, sync write, async read, parameterised width/depth).
- The FSM and pointer logic stay in btle_rx_pdu_buffer.

Test Plan:
1. hit_flag, octets 0x00..0x0A at 16-clk spacing, decode_end with crc_ok=1 on the last octet, out_ready=1 -> 11 beats 0x00..0x0A, out_last only on 0x0A, out_crc_ok=1, pkt_count 1 then 0, drop_cnt=0.
2. Same packet with crc_ok=0 and drop_bad_crc=1 -> no out_valid, crc_err_cnt=1, drop_cnt=1. Repeat with drop_bad_crc=0 -> 11 beats, out_crc_ok=0 on the last beat, crc_err_cnt=2.
3. Three good 11-octet packets with out_ready=0, then out_ready toggling 1/0 each clk -> pkt_count=3, then 33 beats in order with no loss or duplication, 3 out_last pulses, pkt_count ends at 0.
4. ADDR_WIDTH=4, out_ready=0, one 20-octet packet -> dropped, drop_cnt=1, no output, wr_ptr == commit_ptr. A following 5-octet packet commits correctly.
5. hit_flag, 4 octets, second hit_flag, 3 octets, decode_end with crc_ok=1 -> only the 3-octet packet is output, drop_cnt=1.
6. Assert rst after 5 octets of a packet, then send a good 2-octet packet -> all outputs are at reset values after rst, then exactly 2 beats are output.
